// File: rtl/ysyx_24110015_arb_pkg.sv
// Shared types for the IFU/LSU AXI-Lite arbiter: grant states, master IDs, bus widths.
package ysyx_24110015_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFU_RD = 2'd1,
    LSU_RD = 2'd2,
    LSU_WR = 2'd3
  } arb_state_t;

  localparam logic MST_IFU = 1'b0;
  localparam logic MST_LSU = 1'b1;

endpackage

// File: rtl/axi_lite_if.sv
// AXI-Lite bundle (32-bit address/data, 4-bit strobe) with master and slave views.
interface axi_lite_if;
  import ysyx_24110015_arb_pkg::*;

  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

endinterface

// File: rtl/ysyx_24110015_arb_pick.sv
// Combinational grant selector. With ARB_RR_EN defined, IFU/LSU ties alternate on
// last_grant; otherwise the LSU has fixed priority. LSU writes always beat LSU reads.
module ysyx_24110015_arb_pick
  import ysyx_24110015_arb_pkg::*;
(
  input  logic       ifu_rd,
  input  logic       lsu_rd,
  input  logic       lsu_wr,
  input  logic       last_grant,
  output arb_state_t next_state
);

  logic       lsu_req;
  logic       lsu_wins;
  arb_state_t lsu_state;

  assign lsu_req   = lsu_rd | lsu_wr;
  assign lsu_state = lsu_wr ? LSU_WR : LSU_RD;

`ifdef ARB_RR_EN
  // On a tie the master that did not win last time goes first.
  assign lsu_wins = lsu_req & (~ifu_rd | (last_grant == MST_IFU));
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
  assign lsu_wins          = lsu_req;
`endif

  always_comb begin
    next_state = IDLE;
    if (lsu_wins) begin
      next_state = lsu_state;
    end else if (ifu_rd) begin
      next_state = IFU_RD;
    end
  end

endmodule

// File: rtl/ysyx_24110015_axi_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one-slave AXI-Lite arbiter, one whole
// transaction per grant. Define ARB_RR_EN for round-robin; default is LSU-first priority.
module ysyx_24110015_axi_arbiter
  import ysyx_24110015_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  axi_lite_if.slave  ifu,
  axi_lite_if.slave  lsu,
  axi_lite_if.master mem
);

  arb_state_t state_reg;
  arb_state_t pick_state;
  logic       addr_done_reg;
  logic       w_done_reg;
  logic       last_grant;

  ysyx_24110015_arb_pick u_pick (
    .ifu_rd     (ifu.arvalid),
    .lsu_rd     (lsu.arvalid),
    .lsu_wr     (lsu.awvalid & lsu.wvalid),
    .last_grant (last_grant),
    .next_state (pick_state)
  );

`ifdef ARB_RR_EN
  logic last_grant_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_reg <= MST_IFU;
    end else if (state_reg == IDLE && pick_state != IDLE) begin
      last_grant_reg <= (pick_state == IFU_RD) ? MST_IFU : MST_LSU;
    end
  end

  assign last_grant = last_grant_reg;
`else
  assign last_grant = MST_IFU;
`endif

  // The IFU port never writes; its write-side inputs are deliberately ignored.
  logic unused_ifu;
  assign unused_ifu = ^{ifu.awaddr, ifu.awvalid, ifu.wdata, ifu.wstrb, ifu.wvalid, ifu.bready};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      addr_done_reg <= 1'b0;
      w_done_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_reg     <= pick_state;
          addr_done_reg <= 1'b0;
          w_done_reg    <= 1'b0;
        end
        IFU_RD, LSU_RD: begin
          if (mem.arvalid && mem.arready) addr_done_reg <= 1'b1;
          if (mem.rvalid && mem.rready)   state_reg     <= IDLE;
        end
        LSU_WR: begin
          if (mem.awvalid && mem.awready) addr_done_reg <= 1'b1;
          if (mem.wvalid && mem.wready)   w_done_reg    <= 1'b1;
          if (mem.bvalid && mem.bready)   state_reg     <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Forwarding; the done flags mask valid and ready so each handshake happens once.
  always_comb begin
    mem.araddr  = '0;
    mem.arvalid = 1'b0;
    mem.rready  = 1'b0;
    mem.awaddr  = '0;
    mem.awvalid = 1'b0;
    mem.wdata   = '0;
    mem.wstrb   = '0;
    mem.wvalid  = 1'b0;
    mem.bready  = 1'b0;
    ifu.arready = 1'b0;
    ifu.rdata   = '0;
    ifu.rresp   = '0;
    ifu.rvalid  = 1'b0;
    ifu.awready = 1'b0;
    ifu.wready  = 1'b0;
    ifu.bresp   = '0;
    ifu.bvalid  = 1'b0;
    lsu.arready = 1'b0;
    lsu.rdata   = '0;
    lsu.rresp   = '0;
    lsu.rvalid  = 1'b0;
    lsu.awready = 1'b0;
    lsu.wready  = 1'b0;
    lsu.bresp   = '0;
    lsu.bvalid  = 1'b0;
    case (state_reg)
      IFU_RD: begin
        mem.araddr  = ifu.araddr;
        mem.arvalid = ifu.arvalid & ~addr_done_reg;
        ifu.arready = mem.arready & ~addr_done_reg;
        mem.rready  = ifu.rready;
        ifu.rdata   = mem.rdata;
        ifu.rresp   = mem.rresp;
        ifu.rvalid  = mem.rvalid;
      end
      LSU_RD: begin
        mem.araddr  = lsu.araddr;
        mem.arvalid = lsu.arvalid & ~addr_done_reg;
        lsu.arready = mem.arready & ~addr_done_reg;
        mem.rready  = lsu.rready;
        lsu.rdata   = mem.rdata;
        lsu.rresp   = mem.rresp;
        lsu.rvalid  = mem.rvalid;
      end
      LSU_WR: begin
        mem.awaddr  = lsu.awaddr;
        mem.awvalid = lsu.awvalid & ~addr_done_reg;
        lsu.awready = mem.awready & ~addr_done_reg;
        mem.wdata   = lsu.wdata;
        mem.wstrb   = lsu.wstrb;
        mem.wvalid  = lsu.wvalid & ~w_done_reg;
        lsu.wready  = mem.wready & ~w_done_reg;
        mem.bready  = lsu.bready;
        lsu.bresp   = mem.bresp;
        lsu.bvalid  = mem.bvalid;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_24110015_axi_arbiter.sv
// Directed bench for the IFU/LSU arbiter with a latency-programmable slave model.
// Build with or without ARB_RR_EN; grant-order expectations follow the same macro.
module tb_ysyx_24110015_axi_arbiter;
  import ysyx_24110015_arb_pkg::*;

  logic clk;
  logic rst;

  axi_lite_if ifu_if ();
  axi_lite_if lsu_if ();
  axi_lite_if mem_if ();

  ysyx_24110015_axi_arbiter dut (
    .clk (clk),
    .rst (rst),
    .ifu (ifu_if),
    .lsu (lsu_if),
    .mem (mem_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- slave model ----------------
  int          r_lat, aw_dly, w_dly, b_lat;
  logic        s_rvalid, s_bvalid, aw_got, w_got;
  logic [31:0] s_rdata, s_waddr, s_wdata;
  logic [3:0]  s_wstrb;
  int          r_cnt, b_cnt, aw_wait, w_wait;
  int          ar_hs, aw_hs, w_hs;

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return (a == 32'h8000_0000) ? 32'h0010_0073 : ~a;
  endfunction

  assign mem_if.arready = 1'b1;
  assign mem_if.awready = mem_if.awvalid && (aw_wait >= aw_dly);
  assign mem_if.wready  = mem_if.wvalid && (w_wait >= w_dly);
  assign mem_if.rdata   = s_rdata;
  assign mem_if.rresp   = 2'b00;
  assign mem_if.rvalid  = s_rvalid;
  assign mem_if.bresp   = 2'b00;
  assign mem_if.bvalid  = s_bvalid;

  always @(posedge clk) begin
    if (rst) begin
      s_rvalid <= 1'b0; s_bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
      s_rdata <= '0; r_cnt <= 0; b_cnt <= 0; aw_wait <= 0; w_wait <= 0;
      ar_hs <= 0; aw_hs <= 0; w_hs <= 0;
    end else begin
      if (s_rvalid && mem_if.rready) s_rvalid <= 1'b0;
      if (mem_if.arvalid && mem_if.arready) begin
        ar_hs   <= ar_hs + 1;
        s_rdata <= rd_model(mem_if.araddr);
        if (r_lat <= 1) s_rvalid <= 1'b1;
        else            r_cnt    <= r_lat - 1;
      end else if (r_cnt > 0) begin
        r_cnt <= r_cnt - 1;
        if (r_cnt == 1) s_rvalid <= 1'b1;
      end
      if (mem_if.awvalid && mem_if.awready) begin
        aw_hs <= aw_hs + 1; aw_got <= 1'b1; aw_wait <= 0; s_waddr <= mem_if.awaddr;
      end else if (mem_if.awvalid) begin
        aw_wait <= aw_wait + 1;
      end
      if (mem_if.wvalid && mem_if.wready) begin
        w_hs <= w_hs + 1; w_got <= 1'b1; w_wait <= 0;
        s_wdata <= mem_if.wdata; s_wstrb <= mem_if.wstrb;
      end else if (mem_if.wvalid) begin
        w_wait <= w_wait + 1;
      end
      if (aw_got && w_got) begin
        aw_got <= 1'b0; w_got <= 1'b0; b_cnt <= b_lat;
      end
      if (b_cnt > 0) begin
        b_cnt <= b_cnt - 1;
        if (b_cnt == 1) s_bvalid <= 1'b1;
      end
      if (s_bvalid && mem_if.bready) s_bvalid <= 1'b0;
    end
  end

  // ---------------- master models ----------------
  logic        ifu_ar_pend, ifu_rearm;
  logic [31:0] ifu_addr;
  logic        lsu_ar_pend, lsu_aw_pend, lsu_w_pend, lsu_aw_hold;
  logic [31:0] lsu_raddr, lsu_waddr, lsu_wdata;
  logic [3:0]  lsu_wstrb;
  int          lsu_rd_target;
  int          cyc = 0;
  int          ifu_ar_cyc, ifu_r_cyc, lsu_ar_cyc, lsu_aw_cyc, lsu_w_cyc, lsu_b_cyc;
  int          ifu_rd_done = 0, lsu_rd_done = 0, lsu_wr_done = 0;
  logic [31:0] ifu_rdata_last, lsu_rdata_last;
  int          glog[$];

  // One cycle: drive at negedge, sample just after, and record handshakes.
  task automatic tick();
    @(negedge clk);
    ifu_if.arvalid = ifu_ar_pend;
    ifu_if.araddr  = ifu_addr;
    lsu_if.arvalid = lsu_ar_pend;
    lsu_if.araddr  = lsu_raddr;
    lsu_if.awvalid = lsu_aw_pend;
    lsu_if.awaddr  = lsu_waddr;
    lsu_if.wvalid  = lsu_w_pend;
    lsu_if.wdata   = lsu_wdata;
    lsu_if.wstrb   = lsu_wstrb;
    #1;
    cyc++;
    if (ifu_if.arvalid && ifu_if.arready) begin
      ifu_ar_pend = 1'b0; ifu_ar_cyc = cyc; glog.push_back(int'(MST_IFU));
    end
    if (ifu_if.rvalid && ifu_if.rready) begin
      ifu_r_cyc = cyc; ifu_rdata_last = ifu_if.rdata; ifu_rd_done++;
      if (ifu_rearm) ifu_ar_pend = 1'b1;
    end
    if (lsu_if.arvalid && lsu_if.arready) begin
      lsu_ar_pend = 1'b0; lsu_ar_cyc = cyc; glog.push_back(int'(MST_LSU));
    end
    if (lsu_if.rvalid && lsu_if.rready) begin
      lsu_rdata_last = lsu_if.rdata; lsu_rd_done++;
      if (lsu_rd_done < lsu_rd_target) lsu_ar_pend = 1'b1;
    end
    if (lsu_if.awvalid && lsu_if.awready) begin
      if (!lsu_aw_hold) lsu_aw_pend = 1'b0;
      lsu_aw_cyc = cyc; glog.push_back(int'(MST_LSU));
    end
    if (lsu_if.wvalid && lsu_if.wready) begin
      lsu_w_pend = 1'b0; lsu_w_cyc = cyc;
    end
    if (lsu_if.bvalid && lsu_if.bready) begin
      lsu_aw_pend = 1'b0; lsu_b_cyc = cyc; lsu_wr_done++;
    end
  endtask

  int          gbase, wr0, rd0, rd1, early, aw0, w0, aw_after, w_gap, n_lsu_first, alt_viol, nlog;
  logic        awd, wd, seen_ifu;
  logic [31:0] exp_first;

  initial begin
    rst = 1'b1;
    ifu_ar_pend = 1'b0; ifu_rearm = 1'b0; ifu_addr = '0;
    lsu_ar_pend = 1'b0; lsu_aw_pend = 1'b0; lsu_w_pend = 1'b0; lsu_aw_hold = 1'b0;
    lsu_raddr = '0; lsu_waddr = '0; lsu_wdata = '0; lsu_wstrb = '0; lsu_rd_target = 0;
    r_lat = 1; aw_dly = 0; w_dly = 0; b_lat = 1;
    ifu_if.awaddr = '0; ifu_if.awvalid = 1'b0; ifu_if.wdata = '0; ifu_if.wstrb = '0;
    ifu_if.wvalid = 1'b0; ifu_if.bready = 1'b0; ifu_if.rready = 1'b1;
    lsu_if.rready = 1'b1; lsu_if.bready = 1'b1;

    // Reset holds everything quiet even with requests pending.
    ifu_ar_pend = 1'b1; lsu_aw_pend = 1'b1; lsu_w_pend = 1'b1;
    repeat (3) tick();
    check_eq("rst_state", dut.state_reg, IDLE);
    check_eq("rst_mem_arvalid", mem_if.arvalid, 0);
    check_eq("rst_mem_awvalid", mem_if.awvalid, 0);
    check_eq("rst_mem_wvalid", mem_if.wvalid, 0);
    check_eq("rst_ifu_arready", ifu_if.arready, 0);
    check_eq("rst_lsu_awready", lsu_if.awready, 0);
    ifu_ar_pend = 1'b0; lsu_aw_pend = 1'b0; lsu_w_pend = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // IFU read alone, 1-cycle slave.
    ifu_addr = 32'h8000_0000; ifu_ar_pend = 1'b1;
    tick();
    check_eq("t1_idle_no_arvalid", mem_if.arvalid, 0);
    tick();
    check_eq("t1_arvalid_n_plus_1", mem_if.arvalid, 1);
    check_eq("t1_araddr", mem_if.araddr, 32'h8000_0000);
    tick();
    check_eq("t1_rvalid", ifu_if.rvalid, 1);
    check_eq("t1_rdata", ifu_if.rdata, 32'h0010_0073);
    tick();
    check_eq("t1_back_idle", dut.state_reg, IDLE);

    // Simultaneous IFU read and LSU write: LSU first, IFU after one dead cycle.
    gbase = glog.size();
    ifu_addr = 32'h8000_0004; ifu_ar_pend = 1'b1;
    lsu_waddr = 32'h8000_1000; lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'hF;
    lsu_aw_pend = 1'b1; lsu_w_pend = 1'b1;
    wr0 = lsu_wr_done; early = 0;
    for (int i = 0; i < 30 && lsu_wr_done == wr0; i++) begin
      tick();
      if (ifu_if.arready) early++;
    end
    check_eq("t2_b_done", lsu_wr_done, wr0 + 1);
    check_eq("t2_lsu_first", (glog.size() > gbase) ? glog[gbase] : 9, MST_LSU);
    check_eq("t2_ifu_arready_held", early, 0);
    check_eq("t2_awaddr", s_waddr, 32'h8000_1000);
    check_eq("t2_wdata", s_wdata, 32'hDEAD_BEEF);
    check_eq("t2_wstrb", s_wstrb, 4'hF);
    rd0 = ifu_rd_done;
    for (int i = 0; i < 30 && ifu_ar_pend; i++) tick();
    check_eq("t2_ifu_after_dead_cycle", ifu_ar_cyc, lsu_b_cyc + 2);
    for (int i = 0; i < 30 && ifu_rd_done == rd0; i++) tick();
    check_eq("t2_ifu_rdata", ifu_rdata_last, 32'h7FFF_FFFB);
    tick();

    // LSU write alone, then a second simultaneous pair.
    lsu_waddr = 32'h8000_1004; lsu_wdata = 32'h0000_00A5; lsu_wstrb = 4'h1;
    lsu_aw_pend = 1'b1; lsu_w_pend = 1'b1; wr0 = lsu_wr_done;
    for (int i = 0; i < 30 && lsu_wr_done == wr0; i++) tick();
    check_eq("t2b_lsu_alone_done", lsu_wr_done, wr0 + 1);
    tick();
    gbase = glog.size();
    ifu_addr = 32'h8000_000C; ifu_ar_pend = 1'b1;
    lsu_waddr = 32'h8000_1008; lsu_wdata = 32'h5555_AAAA; lsu_wstrb = 4'hF;
    lsu_aw_pend = 1'b1; lsu_w_pend = 1'b1;
    wr0 = lsu_wr_done; rd0 = ifu_rd_done;
    for (int i = 0; i < 60 && (lsu_wr_done == wr0 || ifu_rd_done == rd0); i++) tick();
`ifdef ARB_RR_EN
    exp_first = 32'(MST_IFU);
`else
    exp_first = 32'(MST_LSU);
`endif
    check_eq("t2c_first_grant", (glog.size() > gbase) ? glog[gbase] : 9, exp_first);
    check_eq("t2c_second_grant", (glog.size() > gbase + 1) ? glog[gbase + 1] : 9, exp_first ^ 32'd1);
    check_eq("t2c_ifu_rdata", ifu_rdata_last, 32'h7FFF_FFF3);
    tick();

    // LSU read raised during a slow IFU read.
    ifu_addr = 32'h8000_0008; ifu_ar_pend = 1'b1; r_lat = 5;
    tick();
    tick();
    check_eq("t3_ifu_ar_taken", ifu_ar_pend, 0);
    lsu_raddr = 32'h8000_2000; lsu_ar_pend = 1'b1;
    early = 0; rd0 = ifu_rd_done;
    for (int i = 0; i < 40 && ifu_rd_done == rd0; i++) begin
      tick();
      if (lsu_if.arready) early++;
    end
    check_eq("t3_r_latency", ifu_r_cyc - ifu_ar_cyc, 5);
    check_eq("t3_lsu_arready_held", early, 0);
    r_lat = 1;
    for (int i = 0; i < 30 && lsu_ar_pend; i++) tick();
    check_eq("t3_lsu_grant_cycle", lsu_ar_cyc, ifu_r_cyc + 2);
    rd1 = lsu_rd_done;
    for (int i = 0; i < 30 && lsu_rd_done == rd1; i++) tick();
    check_eq("t3_lsu_rdata", lsu_rdata_last, 32'h7FFF_DFFF);
    tick();

    // AW accepted 3 cycles before W; master keeps AW valid to expose duplicates.
    aw_dly = 0; w_dly = 3; lsu_aw_hold = 1'b1;
    lsu_waddr = 32'h8000_3000; lsu_wdata = 32'h1234_5678; lsu_wstrb = 4'h3;
    aw0 = aw_hs; w0 = w_hs; wr0 = lsu_wr_done;
    aw_after = 0; w_gap = 0; awd = 1'b0; wd = 1'b0;
    lsu_aw_pend = 1'b1; lsu_w_pend = 1'b1;
    for (int i = 0; i < 40 && lsu_wr_done == wr0; i++) begin
      tick();
      if (awd && mem_if.awvalid) aw_after++;
      if (awd && !wd && !mem_if.wvalid) w_gap++;
      if (mem_if.awvalid && mem_if.awready) awd = 1'b1;
      if (mem_if.wvalid && mem_if.wready) wd = 1'b1;
    end
    check_eq("t4_b_done", lsu_wr_done, wr0 + 1);
    check_eq("t4_aw_once", aw_hs - aw0, 1);
    check_eq("t4_w_once", w_hs - w0, 1);
    check_eq("t4_awvalid_dropped", aw_after, 0);
    check_eq("t4_wvalid_held", w_gap, 0);
    check_eq("t4_skew", lsu_w_cyc - lsu_aw_cyc, 3);
    check_eq("t4_wdata", s_wdata, 32'h1234_5678);
    check_eq("t4_wstrb", s_wstrb, 4'h3);
    lsu_aw_hold = 1'b0; w_dly = 0;
    tick();

    // Reset in the middle of a write, before B arrives.
    b_lat = 8;
    lsu_waddr = 32'h8000_4000; lsu_wdata = 32'hCAFE_F00D; lsu_wstrb = 4'hF;
    lsu_aw_pend = 1'b1; lsu_w_pend = 1'b1;
    for (int i = 0; i < 20 && (lsu_aw_pend || lsu_w_pend); i++) tick();
    tick();
    check_eq("t5_state_wr", dut.state_reg, LSU_WR);
    check_eq("t5_no_bvalid_yet", mem_if.bvalid, 0);
    rst = 1'b1;
    lsu_aw_pend = 1'b0; lsu_w_pend = 1'b0; lsu_ar_pend = 1'b0; ifu_ar_pend = 1'b0;
    tick();
    check_eq("t5_state_idle", dut.state_reg, IDLE);
    check_eq("t5_mem_awvalid", mem_if.awvalid, 0);
    check_eq("t5_mem_wvalid", mem_if.wvalid, 0);
    check_eq("t5_mem_arvalid", mem_if.arvalid, 0);
    check_eq("t5_mem_bready", mem_if.bready, 0);
`ifdef ARB_RR_EN
    check_eq("t5_ptr_cleared", dut.last_grant_reg, MST_IFU);
`endif
    rst = 1'b0; b_lat = 1;
    tick();

    // Both masters stream reads; LSU issues 100.
    gbase = glog.size();
    lsu_raddr = 32'h8000_5000; ifu_addr = 32'h8000_0010;
    lsu_rd_done = 0; lsu_rd_target = 100; ifu_rearm = 1'b1;
    rd0 = ifu_rd_done;
    ifu_ar_pend = 1'b1; lsu_ar_pend = 1'b1;
    for (int i = 0; i < 2000 && !(lsu_rd_done >= 100 && ifu_rd_done > rd0); i++) tick();
    check_eq("t6_lsu_count", lsu_rd_done, 100);
    n_lsu_first = 0; seen_ifu = 1'b0; alt_viol = 0;
    nlog = glog.size() - gbase;
    for (int i = 0; i < nlog; i++) begin
      if (glog[gbase + i] == int'(MST_IFU)) seen_ifu = 1'b1;
      else if (!seen_ifu) n_lsu_first++;
      if (i > 0 && i < 100 && glog[gbase + i] == glog[gbase + i - 1]) alt_viol++;
    end
    check_eq("t6_first_grant_lsu", (nlog > 0) ? glog[gbase] : 9, MST_LSU);
`ifdef ARB_RR_EN
    check_eq("t6_alternation", alt_viol, 0);
`else
    check_eq("t6_lsu_before_ifu", n_lsu_first, 100);
`endif
    ifu_rearm = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check_eq("t6_final_idle", dut.state_reg, IDLE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
